// File: rtl/bk_sub_16b_pipe.sv
// -----------------------------------------------------------------------------
// bk_sub_16b_pipe
// 16-bit two's-complement subtractor (D = X - Y - Bin) built on a Brent-Kung
// parallel-prefix carry network, split over two register stages with
// valid/ready flow control on both ends.
//
// The subtraction is computed as X + ~Y + Cin with Cin = ~Bin, so the carry
// out of bit 15 is the inverted unsigned borrow.
//
// Stage 1 : generate/propagate plus the four up-sweep levels of the tree.
// Stage 2 : down-sweep, per-bit carries, difference, borrow and overflow.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   X, Y, Bin valid this cycle
//   in_ready   block can accept operands this cycle (combinational)
//   X, Y       minuend / subtrahend
//   Bin        borrow-in (1 = subtract an extra 1)
//   out_valid  D, Bout, Ovf hold a valid result
//   out_ready  downstream accepts the result this cycle
//   D          difference, X - Y - Bin mod 2^16
//   Bout       unsigned borrow-out, 1 iff X < Y + Bin
//   Ovf        signed overflow of the subtraction
// -----------------------------------------------------------------------------
module bk_sub_16b_pipe #(
  parameter int WIDTH = 16  // tree below is hard-wired for 16 bits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf
);

  // Prefix carry operator: (Ga | (Pa & Gb), Pa & Pb); 'a' is the upper group.
  function automatic logic [1:0] bk_op(input logic ga, input logic pa,
                                       input logic gb, input logic pb);
    return {ga | (pa & gb), pa & pb};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic v1_r;
  logic v2_r;
  logic adv1_s;
  logic adv2_s;

  // Stage advance enables: a stage may load when empty or when the stage after it moves.
  always_comb begin
    adv2_s   = ~v2_r | out_ready;
    adv1_s   = ~v1_r | adv2_s;
    in_ready = adv1_s;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: generate/propagate and up-sweep
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] g0_s, p0_s;
  logic [WIDTH-1:0] l1_g_s, l1_p_s;
  logic [WIDTH-1:0] l2_g_s, l2_p_s;
  logic [WIDTH-1:0] l3_g_s, l3_p_s;
  logic [WIDTH-1:0] l4_g_s, l4_p_s;
  logic             cin_s;

  // Bit-level generate/propagate of X + ~Y, and the carry-in derived from Bin.
  always_comb begin
    g0_s  = X & ~Y;
    p0_s  = X ^ ~Y;
    cin_s = ~Bin;
  end

  // Up-sweep levels 1-4: span-2 at odd bits, span-4 at 3/7/11/15, span-8 at 7/15, span-16 at 15.
  always_comb begin
    l1_g_s = g0_s;
    l1_p_s = p0_s;
    for (int i = 1; i < WIDTH; i += 2) begin
      {l1_g_s[i], l1_p_s[i]} = bk_op(g0_s[i], p0_s[i], g0_s[i-1], p0_s[i-1]);
    end

    l2_g_s = l1_g_s;
    l2_p_s = l1_p_s;
    for (int i = 3; i < WIDTH; i += 4) begin
      {l2_g_s[i], l2_p_s[i]} = bk_op(l1_g_s[i], l1_p_s[i], l1_g_s[i-2], l1_p_s[i-2]);
    end

    l3_g_s = l2_g_s;
    l3_p_s = l2_p_s;
    for (int i = 7; i < WIDTH; i += 8) begin
      {l3_g_s[i], l3_p_s[i]} = bk_op(l2_g_s[i], l2_p_s[i], l2_g_s[i-4], l2_p_s[i-4]);
    end

    l4_g_s = l3_g_s;
    l4_p_s = l3_p_s;
    {l4_g_s[15], l4_p_s[15]} = bk_op(l3_g_s[15], l3_p_s[15], l3_g_s[7], l3_p_s[7]);
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] g1_r, p1_r, p0_r;
  logic             cin_r;

  // Stage 1 pipeline register: loads on advance, data only when a real operand arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r  <= 1'b0;
      g1_r  <= {WIDTH{1'b0}};
      p1_r  <= {WIDTH{1'b0}};
      p0_r  <= {WIDTH{1'b0}};
      cin_r <= 1'b0;
    end else if (adv1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        g1_r  <= l4_g_s;
        p1_r  <= l4_p_s;
        p0_r  <= p0_s;
        cin_r <= cin_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: down-sweep, carries and result
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] dn1_g_s, dn1_p_s;
  logic [WIDTH-1:0] dn2_g_s, dn2_p_s;
  logic [WIDTH-1:0] dn3_g_s, dn3_p_s;
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] diff_s;
  logic             bout_s;
  logic             ovf_s;

  // Down-sweep: bit 11 from 7, then 5/9/13 from 3/7/11, then even bits from the odd bit below.
  always_comb begin
    dn1_g_s = g1_r;
    dn1_p_s = p1_r;
    {dn1_g_s[11], dn1_p_s[11]} = bk_op(g1_r[11], p1_r[11], g1_r[7], p1_r[7]);

    dn2_g_s = dn1_g_s;
    dn2_p_s = dn1_p_s;
    for (int i = 5; i < WIDTH; i += 4) begin
      {dn2_g_s[i], dn2_p_s[i]} = bk_op(dn1_g_s[i], dn1_p_s[i], dn1_g_s[i-2], dn1_p_s[i-2]);
    end

    dn3_g_s = dn2_g_s;
    dn3_p_s = dn2_p_s;
    for (int i = 2; i < WIDTH; i += 2) begin
      {dn3_g_s[i], dn3_p_s[i]} = bk_op(dn2_g_s[i], dn2_p_s[i], dn2_g_s[i-1], dn2_p_s[i-1]);
    end
  end

  // Every dn3 bit now spans [i:0], so each carry folds in Cin with one AND-OR.
  always_comb begin
    c_s[0] = cin_r;
    for (int i = 0; i < WIDTH; i++) begin
      c_s[i+1] = dn3_g_s[i] | (dn3_p_s[i] & cin_r);
    end
  end

  // Difference, borrow and overflow. Overflow uses carry-into-MSB xor carry-out,
  // which equals (X[15]^Y[15]) & (X[15]^D[15]) for X + ~Y + Cin and avoids
  // carrying X[15] through stage 1.
  always_comb begin
    diff_s = p0_r ^ c_s[WIDTH-1:0];
    bout_s = ~c_s[WIDTH];
    ovf_s  = c_s[WIDTH] ^ c_s[WIDTH-1];
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             ovf_r;

  // Stage 2 pipeline register: holds while the downstream stalls a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r   <= 1'b0;
      d_r    <= {WIDTH{1'b0}};
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        d_r    <= diff_s;
        bout_r <= bout_s;
        ovf_r  <= ovf_s;
      end
    end
  end

  assign out_valid = v2_r;
  assign D         = d_r;
  assign Bout      = bout_r;
  assign Ovf       = ovf_r;

endmodule

// File: tb/tb_bk_sub_16b_pipe.sv
// -----------------------------------------------------------------------------
// tb_bk_sub_16b_pipe
// Scoreboard bench for bk_sub_16b_pipe. The stimulus side pushes the expected
// {D, Bout, Ovf} whenever an operand is accepted; an independent monitor pops
// and compares whenever a result is transferred, and also checks that a
// stalled result is held stable.
// -----------------------------------------------------------------------------
module tb_bk_sub_16b_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        Bout;
  logic        Ovf;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  bk_sub_16b_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .Ovf       (Ovf)
  );

  // 10-time-unit clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d    = d;
    e.bout = bo;
    e.ovf  = ov;
    return e;
  endfunction

  // Reference: unsigned 17-bit difference for D/Bout, integer range test for Ovf.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic b);
    logic [16:0] t;
    int          s;
    exp_t        e;
    t      = {1'b0, x} - {1'b0, y} - {16'd0, b};
    s      = int'($signed(x)) - int'($signed(y)) - int'(b);
    e.d    = t[15:0];
    e.bout = t[16];
    e.ovf  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  // Present one operand at a falling edge, hold it until accepted (bounded).
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic b, input exp_t e);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    X        = x;
    Y        = y;
    Bin      = b;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (in_ready) begin
      exp_q.push_back(e);
    end else begin
      chk_cnt++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compares every transferred result and the stability of stalled results.
  initial begin : monitor
    logic  prev_stall;
    exp_t  held;
    exp_t  e;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", {13'd0, out_valid, D, Bout, Ovf}, {13'd0, 1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_out: got D=0x%0h with empty scoreboard, expected no result", D);
          end else begin
            e = exp_q.pop_front();
            check("result", {14'd0, D, Bout, Ovf}, {14'd0, e});
          end
        end
        prev_stall = out_valid && !out_ready;
        held       = {D, Bout, Ovf};
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = 16'd0;
    Y         = 16'd0;
    Bin       = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_D", {16'd0, D}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_flags", {30'd0, Bout, Ovf}, 32'd0);

    // Latency: result visible after the second edge following acceptance.
    out_ready = 1'b1;
    send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
    @(negedge clk);
    #1;
    check("lat_edge1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("lat_edge2", {31'd0, out_valid}, 32'd1);

    // Directed vectors, back-to-back.
    send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1));
    send(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b1));
    send(16'h1234, 16'h1234, 1'b1, mk(16'hFFFF, 1'b1, 1'b0));
    send(16'hFFFF, 16'h0000, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h0000, 16'h0000, 1'b0, mk(16'h0000, 1'b0, 1'b0));
    send(16'h8000, 16'h8000, 1'b1, mk(16'hFFFF, 1'b1, 1'b0));
    send(16'h00FF, 16'h0F0F, 1'b0, mk(16'hF1F0, 1'b1, 1'b0));
    repeat (4) @(negedge clk);

    // Backpressure: two accepts fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    send(16'h0005, 16'h0003, 1'b0, mk(16'h0002, 1'b0, 1'b0));
    send(16'h0003, 16'h0005, 1'b0, mk(16'hFFFE, 1'b1, 1'b0));
    @(negedge clk);
    #1;
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head_D", {16'd0, D}, 32'h0002);
    check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      X        = 16'hFFFF;
      Y        = 16'h0001;
      Bin      = 1'b0;
      #1;
      check("bp_in_ready_stall", {31'd0, in_ready}, 32'd0);
    end
    // Release: accept and drain in the same cycle, no bubbles.
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    check("bp_drain0", {31'd0, out_valid}, 32'd1);
    if (in_ready) exp_q.push_back(mk(16'hFFFE, 1'b0, 1'b0));
    @(negedge clk);
    X   = 16'h8000;
    Y   = 16'h7FFF;
    Bin = 1'b0;
    #1;
    check("bp_in_ready_next", {31'd0, in_ready}, 32'd1);
    check("bp_drain1", {31'd0, out_valid}, 32'd1);
    if (in_ready) exp_q.push_back(mk(16'h0001, 1'b0, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_drain2", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #1;
    check("bp_drain3", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #1;
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall with two results in flight.
    out_ready = 1'b0;
    send(16'h0010, 16'h0001, 1'b0, mk(16'h000F, 1'b0, 1'b0));
    send(16'h0001, 16'h0010, 1'b1, mk(16'hFFF0, 1'b1, 1'b0));
    @(negedge clk);
    #1;
    check("mid_full", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out", {13'd0, D, Bout, Ovf}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h00FF, 16'h000F, 1'b0, mk(16'h00F0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_lat2", {31'd0, out_valid}, 32'd1);

    // Random soak with random valid/ready.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      X         = 16'($urandom);
      Y         = 16'($urandom);
      Bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        e = model(X, Y, Bin);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("drain_empty", exp_q.size(), 32'd0);
    check("final_idle", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
